axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4 responder (slave end) in front of one single-port synchronous SRAM macro: the IM/DM memory behind the bus.
- Serves read bursts issued by the CPU-side read masters and write bursts issued by the data-side master, through the AXI interconnect.
- One transaction at a time (no outstanding or interleaved requests); INCR bursts only.

Parameters:
- ID_W, 8, slave-side ID width (master ID plus interconnect master index)
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width; one beat = one SRAM word
- LEN_W, 4, AXLEN width
- MEM_AW, 14, SRAM word-address width (16K words)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S  in  ID_W/ADDR_W/LEN_W/3/2  read address; SIZE and BURST are ignored (treated as 32-bit INCR)
- ARVALID_S in 1, ARREADY_S out 1  read-address handshake
- RID_S/RDATA_S/RRESP_S/RLAST_S  out  ID_W/DATA_W/2/1  read data
- RVALID_S out 1, RREADY_S in 1  read-data handshake
- AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S  in  ID_W/ADDR_W/LEN_W/3/2  write address; SIZE and BURST are ignored
- AWVALID_S in 1, AWREADY_S out 1  write-address handshake
- WDATA_S/WSTRB_S/WLAST_S  in  DATA_W/DATA_W/8/1  write data
- WVALID_S in 1, WREADY_S out 1  write-data handshake
- BID_S/BRESP_S  out  ID_W/2  write response
- BVALID_S out 1, BREADY_S in 1  write-response handshake
- CEB  out  1  SRAM chip enable, active-low
- WEB  out  1  SRAM write enable, active-low
- BWEB  out  DATA_W  SRAM bit-write enable, active-low
- A  out  MEM_AW  SRAM word address
- DI  out  DATA_W  SRAM write data
- DO  in  DATA_W  SRAM read data; valid the cycle after a read; held until the next access

Behaviour:
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- Reset:
  - state=IDLE.
  - All VALID/READY outputs 0; CEB=1, WEB=1, BWEB all 1.
  - Address/ID/len/count registers 0; RRESP/BRESP=0.
  - Reset mid-burst aborts the burst immediately; no further SRAM access.
- IDLE:
  - ARREADY_S=1 and AWREADY_S=!ARVALID_S. Read wins when both are valid; the losing AW waits.
  - AR handshake: latch ID, word address ADDR[MEM_AW+1:2], len; beat count cleared; go to RD_REQ.
  - AW handshake: latch the same fields; go to WR_DATA.
- RD_REQ:
  - CEB=0, WEB=1, A=latched address. Lasts 1 cycle, then RD_DATA.
- RD_DATA:
  - RVALID_S=1, RDATA_S=DO, RID_S=latched ID, RRESP_S=OKAY, RLAST_S=(count==len). CEB=1, so DO holds.
  - RDATA_S is stable while RREADY_S is low.
  - On R handshake: if last, go to IDLE; else address+1, count+1, go to RD_REQ.
  - Latency: AR handshake at cycle T gives first RVALID at T+2. Throughput: 1 beat per 2 cycles.
- WR_DATA:
  - WREADY_S=1. SRAM controls are active only when WVALID_S=1: CEB=0, WEB=0, A=address, DI=WDATA_S, BWEB[8i+7:8i]=~{8{WSTRB_S[i]}}. The write happens in the handshake cycle.
  - On each handshake: address+1, count+1.
  - The handshake with count==len ends the burst and goes to WR_RESP. The beat count governs the end of the burst, not WLAST.
- WR_RESP:
  - BVALID_S=1, BID_S=latched ID, BRESP_S per the optional feature. On B handshake go to IDLE.
- Width rules:
  - The address counter wraps modulo 2^MEM_AW.
  - ADDR[1:0] and bits above MEM_AW+1 are ignored.
  - len=15 gives 16 beats; the count is LEN_W wide.
- READY is never asserted on a channel outside its state. No combinational path from any VALID to the same channel's READY, except the AR-priority term on AWREADY_S.

Optional Feature:
- Macro AXI_SLV_WLAST_CHK_EN.
- Defined: a sticky error flag sets when any beat's WLAST_S != (count==len). BRESP_S=SLVERR (2'b10) if the flag is set, else OKAY. The flag clears on the AW handshake.
- Undefined: no flag; BRESP_S is always OKAY (2'b00).

Decomposition:
- Shared package axi_pkg holds:
  - the FSM state enum
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - BURST_INC=2'b01
  - ID widths (master 4, slave 8)
- No sub-module. The strobe-to-BWEB expansion is a single generate loop inside the block.

Test Plan:
- Single read: preload word 0x10 = 0xDEADBEEF; AR addr 0x40, len 0, ID 0x15 at T -> RVALID at T+2 with RDATA=0xDEADBEEF, RID=0x15, RLAST=1, RRESP=0.
- Burst round-trip: write addr 0x100, len 3, data 1,2,3,4, WSTRB 0xF -> single B with OKAY and matching BID; then read len 3 -> data 1,2,3,4 with RLAST only on the 4th beat.
- Partial strobe: word holds 0x11223344; write 0xAABBCCDD with WSTRB 0101 -> readback 0x11BB33DD.
- AR and AW valid in the same IDLE cycle -> AR accepted, AWREADY=0 until the read's RLAST handshake, then AW accepted; both transactions complete correctly.
- Backpressure: hold RREADY low 5 cycles in RD_DATA and BREADY low 3 cycles -> RDATA/RVALID and BVALID/BID stay stable; no extra SRAM access (CEB=1 throughout).
- Reset mid-burst (beat 2 of 4) -> all outputs at reset values in the same cycle; a subsequent len-0 read returns correct data. With AXI_SLV_WLAST_CHK_EN, WLAST on beat 1 of 4 -> 4 beats written, BRESP=2'b10.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM responder: FSM state encoding, response
// codes, burst type and the master/slave ID widths seen through the interconnect.
package axi_pkg;

  localparam int MST_ID_W  = 4;
  localparam int MST_IDX_W = 4;
  localparam int SLV_ID_W  = MST_ID_W + MST_IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INC   = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 channel bundle between the interconnect (master modport) and the SRAM
// responder (slave modport).
interface axi_sram_slave_if #(
  parameter int ID_W   = axi_pkg::SLV_ID_W,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);

  logic [ID_W-1:0]     ARID_S;
  logic [ADDR_W-1:0]   ARADDR_S;
  logic [LEN_W-1:0]    ARLEN_S;
  logic [2:0]          ARSIZE_S;
  logic [1:0]          ARBURST_S;
  logic                ARVALID_S;
  logic                ARREADY_S;

  logic [ID_W-1:0]     RID_S;
  logic [DATA_W-1:0]   RDATA_S;
  logic [1:0]          RRESP_S;
  logic                RLAST_S;
  logic                RVALID_S;
  logic                RREADY_S;

  logic [ID_W-1:0]     AWID_S;
  logic [ADDR_W-1:0]   AWADDR_S;
  logic [LEN_W-1:0]    AWLEN_S;
  logic [2:0]          AWSIZE_S;
  logic [1:0]          AWBURST_S;
  logic                AWVALID_S;
  logic                AWREADY_S;

  logic [DATA_W-1:0]   WDATA_S;
  logic [DATA_W/8-1:0] WSTRB_S;
  logic                WLAST_S;
  logic                WVALID_S;
  logic                WREADY_S;

  logic [ID_W-1:0]     BID_S;
  logic [1:0]          BRESP_S;
  logic                BVALID_S;
  logic                BREADY_S;

  modport slave (
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S,
    output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  RREADY_S,
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    output WREADY_S,
    output BID_S, BRESP_S, BVALID_S,
    input  BREADY_S
  );

  modport master (
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output RREADY_S,
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    input  WREADY_S,
    input  BID_S, BRESP_S, BVALID_S,
    output BREADY_S
  );

endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 INCR-burst responder in front of a single-port synchronous SRAM, one
// transaction at a time. Define AXI_SLV_WLAST_CHK_EN to report WLAST misuse as SLVERR.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ID_W   = SLV_ID_W,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int MEM_AW = 14
) (
  input  logic                clk,
  input  logic                rstn,
  axi_sram_slave_if.slave     s,
  output logic                CEB,
  output logic                WEB,
  output logic [DATA_W-1:0]   BWEB,
  output logic [MEM_AW-1:0]   A,
  output logic [DATA_W-1:0]   DI,
  input  logic [DATA_W-1:0]   DO
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     id_q;
  logic [MEM_AW-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [1:0]          bresp;
  logic [DATA_W-1:0]   strb_mask;

  logic last_beat, ar_hs, aw_hs, r_hs, w_hs;

  assign last_beat = (cnt_q == len_q);
  assign ar_hs     = s.ARVALID_S && s.ARREADY_S;
  assign aw_hs     = s.AWVALID_S && s.AWREADY_S;
  assign r_hs      = s.RVALID_S  && s.RREADY_S;
  assign w_hs      = s.WVALID_S  && s.WREADY_S;

  for (genvar i = 0; i < DATA_W/8; i++) begin : g_bweb
    assign strb_mask[8*i +: 8] = ~{8{s.WSTRB_S[i]}};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ar_hs)      state_nxt = RD_REQ;
        else if (aw_hs) state_nxt = WR_DATA;
      end
      RD_REQ:  state_nxt = RD_DATA;
      RD_DATA: if (r_hs) state_nxt = last_beat ? IDLE : RD_REQ;
      WR_DATA: if (w_hs && last_beat) state_nxt = WR_RESP;
      WR_RESP: if (s.BREADY_S) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced to their idle values while rstn is low so an abort is
  // visible in the same cycle, not at the next edge.
  always_comb begin
    s.ARREADY_S = 1'b0;
    s.AWREADY_S = 1'b0;
    s.WREADY_S  = 1'b0;
    s.RVALID_S  = 1'b0;
    s.BVALID_S  = 1'b0;
    s.RID_S     = id_q;
    s.RDATA_S   = '0;
    s.RRESP_S   = RESP_OKAY;
    s.RLAST_S   = 1'b0;
    s.BID_S     = id_q;
    s.BRESP_S   = RESP_OKAY;
    CEB         = 1'b1;
    WEB         = 1'b1;
    BWEB        = '1;
    A           = addr_q;
    DI          = '0;
    if (rstn) begin
      unique case (state)
        IDLE: begin
          s.ARREADY_S = 1'b1;
          s.AWREADY_S = !s.ARVALID_S;
        end
        RD_REQ: CEB = 1'b0;
        RD_DATA: begin
          // CEB stays high here, so DO holds across any RREADY backpressure.
          s.RVALID_S = 1'b1;
          s.RDATA_S  = DO;
          s.RLAST_S  = last_beat;
        end
        WR_DATA: begin
          s.WREADY_S = 1'b1;
          if (s.WVALID_S) begin
            CEB  = 1'b0;
            WEB  = 1'b0;
            BWEB = strb_mask;
            DI   = s.WDATA_S;
          end
        end
        WR_RESP: begin
          s.BVALID_S = 1'b1;
          s.BRESP_S  = bresp;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else if (ar_hs) begin
      id_q   <= s.ARID_S;
      addr_q <= s.ARADDR_S[MEM_AW+1:2];
      len_q  <= s.ARLEN_S;
      cnt_q  <= '0;
    end else if (aw_hs) begin
      id_q   <= s.AWID_S;
      addr_q <= s.AWADDR_S[MEM_AW+1:2];
      len_q  <= s.AWLEN_S;
      cnt_q  <= '0;
    end else if ((r_hs && !last_beat) || w_hs) begin
      addr_q <= addr_q + MEM_AW'(1);
      cnt_q  <= cnt_q + LEN_W'(1);
    end
  end

  logic unused_bits;

`ifdef AXI_SLV_WLAST_CHK_EN
  logic wlast_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                   wlast_err_q <= 1'b0;
    else if (aw_hs)                              wlast_err_q <= 1'b0;
    else if (w_hs && (s.WLAST_S != last_beat))   wlast_err_q <= 1'b1;
  end

  assign bresp = wlast_err_q ? RESP_SLVERR : RESP_OKAY;
  assign unused_bits = ^{s.ARADDR_S[ADDR_W-1:MEM_AW+2], s.ARADDR_S[1:0],
                         s.AWADDR_S[ADDR_W-1:MEM_AW+2], s.AWADDR_S[1:0],
                         s.ARSIZE_S, s.ARBURST_S, s.AWSIZE_S, s.AWBURST_S};
`else
  assign bresp = RESP_OKAY;
  // Burst length alone ends a write burst, so WLAST is not consumed here.
  assign unused_bits = ^{s.ARADDR_S[ADDR_W-1:MEM_AW+2], s.ARADDR_S[1:0],
                         s.AWADDR_S[ADDR_W-1:MEM_AW+2], s.AWADDR_S[1:0],
                         s.ARSIZE_S, s.ARBURST_S, s.AWSIZE_S, s.AWBURST_S,
                         s.WLAST_S};
`endif

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised scoreboard bench for axi_sram_slave: a word-array reference model
// predicts every R beat and B response; a monitor pops and compares on handshakes.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int ID_W = 8, ADDR_W = 32, DATA_W = 32, LEN_W = 4, MEM_AW = 14;
  localparam int DEPTH = 1 << MEM_AW;
`ifdef AXI_SLV_WLAST_CHK_EN
  localparam bit WLAST_CHK = 1'b1;
`else
  localparam bit WLAST_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_sram_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  logic              CEB, WEB;
  logic [DATA_W-1:0] BWEB, DI, DO;
  logic [MEM_AW-1:0] A;

  axi_sram_slave #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MEM_AW(MEM_AW)
  ) dut (
    .clk(clk), .rstn(rstn), .s(bus),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
  );

  function automatic logic [31:0] fill_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Behavioural SRAM macro: DO updates only on a read access and holds otherwise.
  // NOTE: the array has no reset; like the real macro its contents survive rstn.
  logic [31:0] sram [DEPTH];
  logic        fill = 1'b0;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= fill_word(i);
    end else if (!CEB) begin
      if (!WEB) sram[A] <= (sram[A] & BWEB) | (DI & ~BWEB);
      else      DO <= sram[A];
    end
  end

  // Reference model and scoreboard
  logic [31:0] ref_mem [DEPTH];
  typedef struct { logic [7:0] id; logic [31:0] data; logic last; } r_exp_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  r_exp_t exp_r[$];
  b_exp_t exp_b[$];

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int aw_hs_cyc, r_done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void apply_write(input logic [13:0] w, input logic [31:0] d, input logic [3:0] st);
    for (int b = 0; b < 4; b++)
      if (st[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
  endfunction

  always @(negedge clk) begin : mon
    r_exp_t er;
    b_exp_t eb;
    if (rstn && bus.RVALID_S && bus.RREADY_S) begin
      if (exp_r.size() == 0) check("r_unexpected_beat", 64'(exp_r.size()), 64'd1);
      else begin
        er = exp_r.pop_front();
        check("rdata", 64'(bus.RDATA_S), 64'(er.data));
        check("rid",   64'(bus.RID_S),   64'(er.id));
        check("rlast", 64'(bus.RLAST_S), 64'(er.last));
        check("rresp", 64'(bus.RRESP_S), 64'(RESP_OKAY));
      end
    end
    if (rstn && bus.BVALID_S && bus.BREADY_S) begin
      if (exp_b.size() == 0) check("b_unexpected", 64'(exp_b.size()), 64'd1);
      else begin
        eb = exp_b.pop_front();
        check("bid",   64'(bus.BID_S),   64'(eb.id));
        check("bresp", 64'(bus.BRESP_S), 64'(eb.resp));
      end
    end
  end

  task automatic aw_req(input logic [7:0] id, input logic [31:0] addr, input int len);
    bit hs = 1'b0;
    bus.AWID_S = id; bus.AWADDR_S = addr; bus.AWLEN_S = 4'(len);
    bus.AWSIZE_S = 3'd2; bus.AWBURST_S = BURST_INC; bus.AWVALID_S = 1'b1;
    for (int n = 0; n < 100 && !hs; n++) begin
      @(negedge clk); hs = bus.AWREADY_S; @(posedge clk); #1;
    end
    check("aw_handshake", 64'(hs), 64'd1);
    aw_hs_cyc = cyc;
    bus.AWVALID_S = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] st, input logic l);
    bit hs = 1'b0;
    bus.WVALID_S = 1'b1; bus.WDATA_S = d; bus.WSTRB_S = st; bus.WLAST_S = l;
    for (int n = 0; n < 20 && !hs; n++) begin
      @(negedge clk); hs = bus.WREADY_S; @(posedge clk); #1;
    end
    check("w_handshake", 64'(hs), 64'd1);
    bus.WVALID_S = 1'b0; bus.WLAST_S = 1'b0;
  endtask

  // Writes wd/ws/wl[0..len]; the model is updated once the burst is accepted.
  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input int bstall, input bit gaps);
    logic [13:0] w;
    bit wlast_err = 1'b0;
    bit seen = 1'b0;
    aw_req(id, addr, len);
    w = addr[15:2];
    for (int k = 0; k <= len; k++) begin
      apply_write(w + 14'(k), wd[k], ws[k]);
      if (wl[k] != (k == len)) wlast_err = 1'b1;
    end
    exp_b.push_back('{id, (wlast_err && WLAST_CHK) ? RESP_SLVERR : RESP_OKAY});
    for (int k = 0; k <= len; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk); check("w_gap_ceb", 64'(CEB), 64'd1); @(posedge clk); #1;
      end
      w_beat(wd[k], ws[k], wl[k]);
    end
    bus.BREADY_S = (bstall == 0);
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.BVALID_S) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("b_valid_seen", 64'(seen), 64'd1);
    for (int st = 0; st < bstall; st++) begin
      @(posedge clk); #1; @(negedge clk);
      check("b_hold_valid", 64'(bus.BVALID_S), 64'd1);
      if (exp_b.size() > 0) check("b_hold_id", 64'(bus.BID_S), 64'(exp_b[0].id));
      check("b_hold_ceb", 64'(CEB), 64'd1);
    end
    @(posedge clk); #1;
    if (bstall > 0) begin
      bus.BREADY_S = 1'b1; @(posedge clk); #1;
    end
    bus.BREADY_S = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len, input int stall);
    logic [13:0] w;
    bit hs = 1'b0;
    bit seen;
    int n;
    w = addr[15:2];
    for (int k = 0; k <= len; k++)
      exp_r.push_back('{id, ref_mem[w + 14'(k)], k == len});
    bus.ARID_S = id; bus.ARADDR_S = addr; bus.ARLEN_S = 4'(len);
    bus.ARSIZE_S = 3'd2; bus.ARBURST_S = BURST_INC; bus.ARVALID_S = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = bus.ARREADY_S; @(posedge clk); #1;
    end
    check("ar_handshake", 64'(hs), 64'd1);
    bus.ARVALID_S = 1'b0;
    bus.RREADY_S = (stall == 0);
    for (int k = 0; k <= len; k++) begin
      seen = 1'b0; n = 0;
      while (n < 20 && !seen) begin
        @(negedge clk); n++;
        if (bus.RVALID_S) seen = 1'b1;
        else begin @(posedge clk); #1; end
      end
      check("r_valid_seen", 64'(seen), 64'd1);
      check(k == 0 ? "r_first_latency" : "r_beat_spacing", 64'(n), 64'd2);
      for (int st = 0; st < stall; st++) begin
        @(posedge clk); #1; @(negedge clk);
        check("r_hold_valid", 64'(bus.RVALID_S), 64'd1);
        if (exp_r.size() > 0) check("r_hold_data", 64'(bus.RDATA_S), 64'(exp_r[0].data));
        check("r_hold_ceb", 64'(CEB), 64'd1);
      end
      @(posedge clk); #1;
      if (stall > 0) begin
        bus.RREADY_S = 1'b1; @(posedge clk); #1; bus.RREADY_S = 1'b0;
      end
    end
    bus.RREADY_S = 1'b0;
    r_done_cyc = cyc;
  endtask

  task automatic set_beats(input int len, input logic [31:0] base, input logic [3:0] st);
    for (int k = 0; k < 16; k++) begin
      wd[k] = base + 32'(k); ws[k] = st; wl[k] = (k == len);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arready"}, 64'(bus.ARREADY_S), 64'd0);
    check({tag, "_awready"}, 64'(bus.AWREADY_S), 64'd0);
    check({tag, "_wready"},  64'(bus.WREADY_S),  64'd0);
    check({tag, "_rvalid"},  64'(bus.RVALID_S),  64'd0);
    check({tag, "_bvalid"},  64'(bus.BVALID_S),  64'd0);
    check({tag, "_ceb"},     64'(CEB),           64'd1);
    check({tag, "_web"},     64'(WEB),           64'd1);
    check({tag, "_bweb"},    64'(BWEB),          64'hFFFF_FFFF);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] rnd, addr;
    logic [13:0] word;
    logic [7:0]  id;
    int len;

    bus.ARVALID_S = 1'b0; bus.AWVALID_S = 1'b0; bus.WVALID_S = 1'b0;
    bus.RREADY_S = 1'b0; bus.BREADY_S = 1'b0;
    bus.ARID_S = '0; bus.ARADDR_S = '0; bus.ARLEN_S = '0; bus.ARSIZE_S = '0; bus.ARBURST_S = '0;
    bus.AWID_S = '0; bus.AWADDR_S = '0; bus.AWLEN_S = '0; bus.AWSIZE_S = '0; bus.AWBURST_S = '0;
    bus.WDATA_S = '0; bus.WSTRB_S = '0; bus.WLAST_S = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill_word(i);
    fill = 1'b1;
    @(posedge clk); #1; fill = 1'b0;

    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rresp", 64'(bus.RRESP_S), 64'd0);
    check("reset_bresp", 64'(bus.BRESP_S), 64'd0);
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);
    check("idle_arready", 64'(bus.ARREADY_S), 64'd1);
    check("idle_awready", 64'(bus.AWREADY_S), 64'd1);
    @(posedge clk); #1;

    // Single read of a preloaded word
    set_beats(0, 32'hDEADBEEF, 4'hF);
    do_write(8'h03, 32'h0000_0040, 0, 0, 1'b0);
    do_read(8'h15, 32'h0000_0040, 0, 0);

    // Burst round trip
    set_beats(3, 32'd1, 4'hF);
    do_write(8'h2A, 32'h0000_0100, 3, 0, 1'b0);
    do_read(8'h31, 32'h0000_0100, 3, 0);

    // Partial strobe merge
    set_beats(0, 32'h11223344, 4'hF);
    do_write(8'h07, 32'h0000_0200, 0, 0, 1'b0);
    set_beats(0, 32'hAABBCCDD, 4'b0101);
    do_write(8'h08, 32'h0000_0200, 0, 0, 1'b0);
    do_read(8'h09, 32'h0000_0200, 0, 0);

    // AR and AW presented together: read first, AW accepted right after RLAST
    set_beats(1, 32'hC0DE_0000, 4'hF);
    @(posedge clk); #1;
    fork
      do_read(8'h40, 32'h0000_0100, 0, 0);
      do_write(8'h41, 32'h0000_0300, 1, 0, 1'b0);
    join
    check("aw_after_rlast", 64'(aw_hs_cyc), 64'(r_done_cyc + 1));
    do_read(8'h42, 32'h0000_0300, 1, 0);

    // Backpressure on R and B
    do_read(8'h55, 32'h0000_0100, 1, 5);
    set_beats(0, 32'h0BAD_F00D, 4'hF);
    do_write(8'h56, 32'h0000_0400, 0, 3, 1'b0);

    // Early WLAST on a 4-beat burst: all beats land, response depends on the check
    set_beats(3, 32'h7000_0000, 4'hF);
    wl[0] = 1'b1; wl[3] = 1'b0;
    do_write(8'h60, 32'h0000_0500, 3, 0, 1'b0);
    do_read(8'h61, 32'h0000_0500, 3, 0);
    set_beats(0, 32'h7100_0000, 4'hF);
    do_write(8'h62, 32'h0000_0600, 0, 0, 1'b0);

    // Address wraps modulo the SRAM depth; upper and low address bits ignored
    set_beats(3, 32'h9900_0000, 4'hF);
    do_write(8'h70, 32'hABCD_FFFB, 3, 0, 1'b0);
    do_read(8'h71, 32'h0000_0000, 1, 0);
    do_read(8'h72, 32'h1234_FFF9, 3, 0);

    // Reset in the middle of beat 2 of a 4-beat write
    aw_req(8'h80, 32'h0000_0800, 3);
    w_beat(32'hA0A0_0000, 4'hF, 1'b0);
    w_beat(32'hA0A0_0001, 4'hF, 1'b0);
    apply_write(14'h200, 32'hA0A0_0000, 4'hF);
    apply_write(14'h201, 32'hA0A0_0001, 4'hF);
    bus.WVALID_S = 1'b1; bus.WDATA_S = 32'hA0A0_0002; bus.WSTRB_S = 4'hF;
    #2; rstn = 1'b0; #1;
    check_idle_outputs("abort");
    bus.WVALID_S = 1'b0;
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    for (int k = 0; k < 4; k++) do_read(8'h81, 32'h0000_0800 + 32'(4 * k), 0, 0);

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 15);
      id = 8'($urandom);
      rnd = $urandom;
      word = ($urandom_range(0, 7) == 0) ? 14'(DEPTH - 1 - $urandom_range(0, 3))
                                         : 14'($urandom_range(0, 255));
      addr = {rnd[31:16], word, rnd[1:0]};
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) begin
          wd[k] = $urandom;
          ws[k] = 4'($urandom);
          wl[k] = (k == len) ^ ($urandom_range(0, 7) == 0);
        end
        do_write(id, addr, len, $urandom_range(0, 2), 1'b1);
      end else begin
        do_read(id, addr, len, $urandom_range(0, 2));
      end
    end

    repeat (4) @(posedge clk);
    check("r_queue_drained", 64'(exp_r.size()), 64'd0);
    check("b_queue_drained", 64'(exp_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
